// File: rtl/riscv_exec_unit.sv
// RV32I/RV64I integer execute stage with optional M-extension.
// Single-cycle ALU/multiply results; divide/remainder via a restoring divider (one quotient bit per cycle).
module riscv_exec_unit #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rd_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd_addr,
   output logic            out_rd_we,
   output logic [XLEN-1:0] out_rd,
   output logic            out_illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic {IDLE, MULDIV} state_t;

   state_t          state_reg;

   logic [XLEN-1:0] div_quo_reg;
   logic [XLEN-1:0] div_rem_reg;
   logic [XLEN-1:0] div_divisor_reg;
   logic [XLEN-1:0] div_rs1_reg;
   logic [CW-1:0]   div_count_reg;
   logic            div_neg_q_reg;
   logic            div_neg_r_reg;
   logic            div_zero_reg;
   logic            div_is_rem_reg;
   logic            div_we_reg;

   // ------------------------------------------------------------------
   // Single-cycle datapath
   // ------------------------------------------------------------------
   logic [XLEN-1:0] operand_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] add_res;
   logic [XLEN-1:0] sub_res;
   logic [XLEN-1:0] sll_res;
   logic [XLEN-1:0] srl_res;
   logic [XLEN-1:0] sra_res;
   logic [XLEN-1:0] slt_res;
   logic [XLEN-1:0] sltu_res;
   logic [XLEN-1:0] mul_result;

   assign operand_b = (opcode == OPC_OP_IMM) ? imm : rs2;
   assign shamt     = operand_b[SHW-1:0];
   assign add_res   = rs1 + operand_b;
   assign sub_res   = rs1 - rs2;
   assign sll_res   = rs1 << shamt;
   assign srl_res   = rs1 >> shamt;
   assign sra_res   = $unsigned($signed(rs1) >>> shamt);
   assign slt_res   = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(operand_b))};
   assign sltu_res  = {{(XLEN-1){1'b0}}, (rs1 < operand_b)};

   generate
      if (ENABLE_M != 0) begin : g_mul
         // Operands sign/zero-extended to 2*XLEN: the truncated product is exact for every MUL variant.
         logic            sign_a;
         logic            sign_b;
         logic [2*XLEN-1:0] ext_a;
         logic [2*XLEN-1:0] ext_b;
         logic [2*XLEN-1:0] prod;

         assign sign_a = (funct3[1:0] != 2'b11) && rs1[XLEN-1];
         assign sign_b = (funct3[1:0] == 2'b01) && rs2[XLEN-1];
         assign ext_a  = {{XLEN{sign_a}}, rs1};
         assign ext_b  = {{XLEN{sign_b}}, rs2};
         assign prod   = ext_a * ext_b;
         assign mul_result = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else begin : g_no_mul
         assign mul_result = '0;
      end
   endgenerate

   logic [XLEN-1:0] alu_result;
   logic            alu_legal;
   logic            start_div;

   always_comb begin
      alu_result = '0;
      alu_legal  = 1'b0;
      start_div  = 1'b0;
      case (opcode)
         OPC_LUI: begin
            alu_result = imm;
            alu_legal  = 1'b1;
         end
         OPC_AUIPC: begin
            alu_result = pc + imm;
            alu_legal  = 1'b1;
         end
         OPC_OP_IMM: begin
            alu_legal = 1'b1;
            case (funct3)
               3'b000: alu_result = add_res;
               3'b010: alu_result = slt_res;
               3'b011: alu_result = sltu_res;
               3'b100: alu_result = rs1 ^ imm;
               3'b110: alu_result = rs1 | imm;
               3'b111: alu_result = rs1 & imm;
               3'b001: begin
                  alu_result = sll_res;
                  alu_legal  = (imm[11:SHW] == '0);
               end
               default: begin
                  // imm[10] picks arithmetic vs logical right shift
                  alu_result = imm[10] ? sra_res : srl_res;
                  alu_legal  = !imm[11] && (imm[9:SHW] == '0);
               end
            endcase
         end
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               alu_legal = 1'b1;
               case (funct3)
                  3'b000:  alu_result = add_res;
                  3'b001:  alu_result = sll_res;
                  3'b010:  alu_result = slt_res;
                  3'b011:  alu_result = sltu_res;
                  3'b100:  alu_result = rs1 ^ rs2;
                  3'b101:  alu_result = srl_res;
                  3'b110:  alu_result = rs1 | rs2;
                  default: alu_result = rs1 & rs2;
               endcase
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  alu_result = sub_res;
                  alu_legal  = 1'b1;
               end else if (funct3 == 3'b101) begin
                  alu_result = sra_res;
                  alu_legal  = 1'b1;
               end
            end else if ((funct7 == F7_MULDIV) && (ENABLE_M != 0)) begin
               alu_legal = 1'b1;
               if (funct3[2]) begin
                  start_div = 1'b1;
               end else begin
                  alu_result = mul_result;
               end
            end
         end
         default: begin
            alu_legal = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Divider setup: operate on magnitudes, fix signs on the last step
   // ------------------------------------------------------------------
   logic            div_signed;
   logic            rs1_neg;
   logic            rs2_neg;
   logic [XLEN-1:0] rs1_mag;
   logic [XLEN-1:0] rs2_mag;

   assign div_signed = !funct3[0];
   assign rs1_neg    = div_signed && rs1[XLEN-1];
   assign rs2_neg    = div_signed && rs2[XLEN-1];
   assign rs1_mag    = rs1_neg ? (~rs1 + 1'b1) : rs1;
   assign rs2_mag    = rs2_neg ? (~rs2 + 1'b1) : rs2;

   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_diff;
   logic            q_bit;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] quo_final;
   logic [XLEN-1:0] rem_final;

   assign rem_shift = {div_rem_reg, div_quo_reg[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, div_divisor_reg};
   assign q_bit     = !rem_diff[XLEN];
   assign rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
   assign quo_next  = {div_quo_reg[XLEN-2:0], q_bit};

   always_comb begin
      quo_final = div_neg_q_reg ? (~quo_next + 1'b1) : quo_next;
      rem_final = div_neg_r_reg ? (~rem_next + 1'b1) : rem_next;
      if (div_zero_reg) begin
         quo_final = '1;
         rem_final = div_rs1_reg;
      end
   end

   assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);

   // ------------------------------------------------------------------
   // Control and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         out_valid       <= 1'b0;
         out_rd_addr     <= '0;
         out_rd_we       <= 1'b0;
         out_rd          <= '0;
         out_illegal     <= 1'b0;
         div_quo_reg     <= '0;
         div_rem_reg     <= '0;
         div_divisor_reg <= '0;
         div_rs1_reg     <= '0;
         div_count_reg   <= '0;
         div_neg_q_reg   <= 1'b0;
         div_neg_r_reg   <= 1'b0;
         div_zero_reg    <= 1'b0;
         div_is_rem_reg  <= 1'b0;
         div_we_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  out_rd_addr <= rd_addr;
                  if (start_div) begin
                     state_reg       <= MULDIV;
                     out_valid       <= 1'b0;
                     div_quo_reg     <= rs1_mag;
                     div_rem_reg     <= '0;
                     div_divisor_reg <= rs2_mag;
                     div_rs1_reg     <= rs1;
                     div_count_reg   <= CW'(XLEN);
                     div_zero_reg    <= (rs2 == '0);
                     div_neg_q_reg   <= (rs1_neg ^ rs2_neg) && (rs2 != '0);
                     div_neg_r_reg   <= rs1_neg;
                     div_is_rem_reg  <= funct3[1];
                     div_we_reg      <= (rd_addr != 5'd0);
                  end else begin
                     out_valid   <= 1'b1;
                     out_illegal <= !alu_legal;
                     out_rd_we   <= alu_legal && (rd_addr != 5'd0);
                     out_rd      <= alu_legal ? alu_result : '0;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            MULDIV: begin
               div_quo_reg   <= quo_next;
               div_rem_reg   <= rem_next;
               div_count_reg <= div_count_reg - 1'b1;
               if (div_count_reg == CW'(1)) begin
                  state_reg   <= IDLE;
                  out_valid   <= 1'b1;
                  out_illegal <= 1'b0;
                  out_rd_we   <= div_we_reg;
                  out_rd      <= div_is_rem_reg ? rem_final : quo_final;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Directed bench for riscv_exec_unit (XLEN=32, ENABLE_M=1): vector table plus divide, backpressure and reset sequences.
module tb_riscv_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  rd_addr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd_addr;
   logic        out_rd_we;
   logic [31:0] out_rd;
   logic        out_illegal;

   int checks = 0;
   int errors = 0;

   riscv_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm), .pc(pc),
      .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr), .out_valid(out_valid),
      .out_ready(out_ready), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [31:0] exp_rd;
      logic        exp_we;
      logic        exp_ill;
   } vec_t;

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im, input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic [31:0] e,
                               input logic we, input logic ill);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.imm = im; v.pc = p; v.rs1 = a; v.rs2 = b;
      v.rd = rd; v.exp_rd = e; v.exp_we = we; v.exp_ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      opcode = v.op; funct3 = v.f3; funct7 = v.f7; imm = v.imm; pc = v.pc;
      rs1 = v.rs1; rs2 = v.rs2; rd_addr = v.rd; in_valid = 1'b1;
   endtask

   task automatic check_result(input string tag, input vec_t v);
      $display("%s op=%02h f3=%0d f7=%02h rs1=%08h rs2=%08h imm=%08h -> rd=%08h we=%0b ill=%0b addr=%0d",
               tag, v.op, v.f3, v.f7, v.rs1, v.rs2, v.imm, out_rd, out_rd_we, out_illegal, out_rd_addr);
      check({tag, " out_valid"}, 64'(out_valid), 64'(1));
      check({tag, " out_rd"}, 64'(out_rd), 64'(v.exp_rd));
      check({tag, " out_rd_we"}, 64'(out_rd_we), 64'(v.exp_we));
      check({tag, " out_illegal"}, 64'(out_illegal), 64'(v.exp_ill));
      check({tag, " out_rd_addr"}, 64'(out_rd_addr), 64'(v.rd));
   endtask

   // Called #1 after a rising edge; result checked #1 after the accepting edge.
   task automatic apply(input vec_t v);
      drive(v);
      #1;
      check("pre-accept in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_result("single", v);
   endtask

   task automatic run_div(input vec_t v);
      int  edges;
      bit  ready_seen;
      drive(v);
      #1;
      check("div in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      edges      = 0;
      ready_seen = 1'b0;
      while (!out_valid && edges < 100) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk);
         #1;
         edges++;
      end
      check("div latency", 64'(edges + 1), 64'(33));
      check("div in_ready low while busy", 64'(ready_seen), 64'(0));
      check_result("div", v);
   endtask

   vec_t vecs[$];
   vec_t divs[$];

   initial begin
      int  edges;
      bit  saw_valid;
      vec_t va;
      vec_t vb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; funct3 = '0; funct7 = '0; imm = '0; pc = '0; rs1 = '0; rs2 = '0; rd_addr = '0;

      vecs.push_back(mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd5, 32'h0, 1, 0));
      vecs.push_back(mk(7'h33, 3'd0, 7'h20, 32'h0, 32'h0, 32'h5, 32'h7, 5'd1, 32'hFFFFFFFE, 1, 0));
      vecs.push_back(mk(7'h33, 3'd5, 7'h20, 32'h0, 32'h0, 32'h80000000, 32'h24, 5'd2, 32'hF8000000, 1, 0));
      vecs.push_back(mk(7'h33, 3'd3, 7'h00, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 5'd3, 32'h1, 1, 0));
      vecs.push_back(mk(7'h33, 3'd2, 7'h00, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 5'd4, 32'h0, 1, 0));
      vecs.push_back(mk(7'h33, 3'd1, 7'h00, 32'h0, 32'h0, 32'h1, 32'h1F, 5'd6, 32'h80000000, 1, 0));
      vecs.push_back(mk(7'h33, 3'd5, 7'h00, 32'h0, 32'h0, 32'h80000000, 32'h4, 5'd7, 32'h08000000, 1, 0));
      vecs.push_back(mk(7'h33, 3'd4, 7'h00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 5'd8, 32'h0FF0, 1, 0));
      vecs.push_back(mk(7'h33, 3'd6, 7'h00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 5'd8, 32'hFFF0, 1, 0));
      vecs.push_back(mk(7'h33, 3'd7, 7'h00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 5'd8, 32'hF000, 1, 0));
      vecs.push_back(mk(7'h37, 3'd0, 7'h00, 32'h12345000, 32'h0, 32'h0, 32'h0, 5'd9, 32'h12345000, 1, 0));
      vecs.push_back(mk(7'h17, 3'd0, 7'h00, 32'h2000, 32'hFFFFF000, 32'h0, 32'h0, 5'd10, 32'h1000, 1, 0));
      vecs.push_back(mk(7'h13, 3'd0, 7'h00, 32'hFFFFFFFF, 32'h0, 32'hA, 32'h0, 5'd11, 32'h9, 1, 0));
      vecs.push_back(mk(7'h13, 3'd2, 7'h00, 32'h3, 32'h0, 32'hFFFFFFFB, 32'h0, 5'd12, 32'h1, 1, 0));
      vecs.push_back(mk(7'h13, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h0, 5'd13, 32'h1, 1, 0));
      vecs.push_back(mk(7'h13, 3'd5, 7'h20, 32'h404, 32'h0, 32'h80000000, 32'h0, 5'd14, 32'hF8000000, 1, 0));
      vecs.push_back(mk(7'h13, 3'd5, 7'h00, 32'h4, 32'h0, 32'h80000000, 32'h0, 5'd15, 32'h08000000, 1, 0));
      vecs.push_back(mk(7'h13, 3'd1, 7'h00, 32'h3, 32'h0, 32'h1, 32'h0, 5'd16, 32'h8, 1, 0));
      vecs.push_back(mk(7'h13, 3'd4, 7'h00, 32'hFFFFFFFF, 32'h0, 32'hFF, 32'h0, 5'd17, 32'hFFFFFF00, 1, 0));
      vecs.push_back(mk(7'h13, 3'd6, 7'h00, 32'hF0, 32'h0, 32'hF, 32'h0, 5'd18, 32'hFF, 1, 0));
      vecs.push_back(mk(7'h13, 3'd7, 7'h00, 32'hFF, 32'h0, 32'h1234, 32'h0, 5'd19, 32'h34, 1, 0));
      vecs.push_back(mk(7'h33, 3'd0, 7'h01, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'h1, 1, 0));
      vecs.push_back(mk(7'h33, 3'd1, 7'h01, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 5'd21, 32'h40000000, 1, 0));
      vecs.push_back(mk(7'h33, 3'd3, 7'h01, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'hFFFFFFFE, 1, 0));
      vecs.push_back(mk(7'h33, 3'd2, 7'h01, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 32'hFFFFFFFF, 1, 0));
      vecs.push_back(mk(7'h13, 3'd0, 7'h00, 32'h1, 32'h0, 32'h1, 32'h0, 5'd0, 32'h2, 0, 0));
      vecs.push_back(mk(7'h7F, 3'd0, 7'h00, 32'h0, 32'h0, 32'h1, 32'h1, 5'd24, 32'h0, 0, 1));
      vecs.push_back(mk(7'h33, 3'd1, 7'h20, 32'h0, 32'h0, 32'h1, 32'h1, 5'd25, 32'h0, 0, 1));
      vecs.push_back(mk(7'h13, 3'd1, 7'h00, 32'h20, 32'h0, 32'h1, 32'h0, 5'd26, 32'h0, 0, 1));

      divs.push_back(mk(7'h33, 3'd4, 7'h01, 32'h0, 32'h0, 32'hFFFFFFF9, 32'h2, 5'd5, 32'hFFFFFFFD, 1, 0));
      divs.push_back(mk(7'h33, 3'd6, 7'h01, 32'h0, 32'h0, 32'hFFFFFFF9, 32'h2, 5'd6, 32'hFFFFFFFF, 1, 0));
      divs.push_back(mk(7'h33, 3'd5, 7'h01, 32'h0, 32'h0, 32'h5, 32'h0, 5'd7, 32'hFFFFFFFF, 1, 0));
      divs.push_back(mk(7'h33, 3'd6, 7'h01, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h0, 1, 0));
      divs.push_back(mk(7'h33, 3'd4, 7'h01, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 1, 0));
      divs.push_back(mk(7'h33, 3'd7, 7'h01, 32'h0, 32'h0, 32'h5, 32'h0, 5'd10, 32'h5, 1, 0));
      divs.push_back(mk(7'h33, 3'd6, 7'h01, 32'h0, 32'h0, 32'hFFFFFFF9, 32'h0, 5'd11, 32'hFFFFFFF9, 1, 0));
      divs.push_back(mk(7'h33, 3'd5, 7'h01, 32'h0, 32'h0, 32'd100, 32'd7, 5'd12, 32'd14, 1, 0));
      divs.push_back(mk(7'h33, 3'd7, 7'h01, 32'h0, 32'h0, 32'd100, 32'd7, 5'd13, 32'd2, 1, 0));
      divs.push_back(mk(7'h33, 3'd4, 7'h01, 32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 1, 0));
      divs.push_back(mk(7'h33, 3'd6, 7'h01, 32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 5'd0, 32'h1, 0, 0));

      // Reset state
      #2;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset out_rd", 64'(out_rd), 64'(0));
      check("reset out_rd_we", 64'(out_rd_we), 64'(0));
      check("reset out_illegal", 64'(out_illegal), 64'(0));
      check("reset out_rd_addr", 64'(out_rd_addr), 64'(0));
      #20;
      rst_n = 1'b1;
      #1;
      check("in_ready after reset", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Single-cycle vectors, back-to-back
      foreach (vecs[i]) apply(vecs[i]);

      // Divides
      foreach (divs[i]) run_div(divs[i]);

      // Backpressure: hold result 0x1234 for 3 cycles
      va = mk(7'h13, 3'd0, 7'h00, 32'h234, 32'h0, 32'h1000, 32'h0, 5'd7, 32'h1234, 1, 0);
      vb = mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 32'h2, 32'h3, 5'd8, 32'h5, 1, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      apply(va);
      drive(vb);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall in_ready", 64'(in_ready), 64'(0));
         @(posedge clk);
         #1;
         check_result("stall hold", va);
      end
      out_ready = 1'b1;
      #1;
      check("release in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_result("after release", vb);

      // Reset in the middle of a division
      drive(divs[0]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", 64'(out_valid), 64'(0));
      check("midreset out_rd", 64'(out_rd), 64'(0));
      check("midreset out_rd_we", 64'(out_rd_we), 64'(0));
      check("midreset out_rd_addr", 64'(out_rd_addr), 64'(0));
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("midreset in_ready", 64'(in_ready), 64'(1));
      saw_valid = 1'b0;
      edges = 0;
      while (edges < 40) begin
         @(posedge clk);
         #1;
         if (out_valid) saw_valid = 1'b1;
         edges++;
      end
      $display("midreset watch: out_valid seen=%0b over %0d cycles", saw_valid, edges);
      check("no result after aborted div", 64'(saw_valid), 64'(0));
      apply(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_exec_unit.md
RISCV_EXEC_UNIT -- requirements
Module: riscv_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter ENABLE_M, default 1, enables RV M-extension multiply/divide.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation presented.
REQ-006 SHALL have port in_ready  output  1  unit accepts operation this cycle.
REQ-007 SHALL have ports opcode/funct3/funct7  input  7/3/7  instruction fields.
REQ-008 SHALL have port imm  input  XLEN  decoded, sign-extended immediate; for LUI/AUIPC already shifted left 12.
REQ-009 SHALL have ports pc/rs1/rs2  input  XLEN  program counter and source operands.
REQ-010 SHALL have port rd_addr  input  5  destination register index.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have ports out_rd_addr/out_rd_we/out_rd  output  5/1/XLEN  writeback index, enable, data.
REQ-014 SHALL have port out_illegal  output  1  operation not supported.

Function
REQ-015 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-017 SHALL hold out_valid, out_rd_addr, out_rd_we, out_rd, out_illegal stable while out_valid && !out_ready.
REQ-018 SHALL implement states IDLE, MULDIV (multi-cycle busy); IDLE->MULDIV on accepted divide/remainder, MULDIV->IDLE when result registered.
REQ-019 SHALL register single-cycle results: out_valid asserts the cycle after acceptance (latency 1); back-to-back acceptance every cycle when out_ready=1.
REQ-020 SHALL support LUI (rd=imm), AUIPC (rd=pc+imm), OP-IMM (ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI) and OP (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND).
REQ-021 SHALL use shift amount = low log2(XLEN) bits of rs2 (OP) or imm (OP-IMM); SRAI selected by imm[10].
REQ-022 SHALL compute SLT/SLTI signed, SLTU/SLTIU unsigned, result 0 or 1 zero-extended.
REQ-023 SHALL wrap all add/sub/AUIPC results modulo 2^XLEN.
REQ-024 SHALL, with ENABLE_M=1, support funct7=0000001 OP: MUL, MULH, MULHSU, MULHU at latency 1; DIV, DIVU, REM, REMU at fixed latency XLEN+1 cycles (restoring, one quotient bit per cycle).
REQ-025 SHALL return, on divide by zero, quotient all ones and remainder = rs1; on signed overflow (min / -1) quotient = min, remainder 0; latency unchanged.
REQ-026 SHALL deassert in_ready throughout MULDIV and until the divide result is taken.
REQ-027 SHALL set out_illegal=1, out_rd_we=0, out_rd=0 for unsupported opcode/funct combinations, and for M operations when ENABLE_M=0; latency 1.
REQ-028 SHALL set out_rd_we=0 when rd_addr==0, otherwise 1 for legal operations.

Reset
REQ-029 SHALL, on rst_n low, immediately clear out_valid, out_rd_we, out_illegal, out_rd, out_rd_addr to 0 and state to IDLE.
REQ-030 SHALL abort an in-flight division on reset, with no result ever presented.
REQ-031 SHALL assert in_ready in the first cycle after rst_n deasserts.

Verification
REQ-032 SHALL pass: XLEN=32, ADD rs1=0xFFFFFFFF rs2=1 rd=5 -> next cycle out_valid=1, out_rd=0, out_rd_we=1, out_rd_addr=5.
REQ-033 SHALL pass: SRA rs1=0x80000000 rs2=0x24 -> out_rd=0xF8000000 (shift 4); SLTU 1,0xFFFFFFFF -> 1; SLT same -> 0.
REQ-034 SHALL pass: DIV rs1=-7 rs2=2 -> out_valid exactly 33 cycles after acceptance, out_rd=0xFFFFFFFD; in_ready low meanwhile; REM -> 0xFFFFFFFF.
REQ-035 SHALL pass: DIVU rs1=5 rs2=0 -> 0xFFFFFFFF; REM 0x80000000,0xFFFFFFFF -> 0.
REQ-036 SHALL pass: out_ready low 3 cycles with result 0x1234 pending -> outputs stable, in_ready low, no new accept; release -> accept resumes same cycle.
REQ-037 SHALL pass: rst_n low mid-division (cycle 10) -> out_valid 0 immediately, no result after release; ADDI rd=0 -> out_rd_we=0; opcode 0x7F -> out_illegal=1.
